// File: rtl/XT_UART.sv
// rtl/XT_UART.sv - shared types for the UART TX feeder
package XT_UART;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push on a full FIFO is refused even when a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte queue that paces writes into the UART TX register
module uart_tx_feeder
    import XT_UART::*;
#(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                   hb_clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    output logic                   s_ready,
    input  logic                   flush,
    input  logic                   uart_tx_ready,
    output logic                   uart_wen,
    output logic [7:0]             uart_wdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   idle,
    output logic                   byte_done,
    output logic                   timeout_err
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    feeder_state_t state_q;
    logic [TW-1:0] timer_q;
    logic          wen_q;
    uart_byte_t    wdata_q;
    logic          done_q;
    logic          terr_q;
    logic          full;
    logic          push;
    logic          pop;
    uart_byte_t    head;

    assign s_ready = !full && !flush;
    assign push    = s_valid && s_ready;
    // Popping during a flush would issue a byte the flush is meant to drop.
    assign pop     = (state_q == IDLE) && !empty && uart_tx_ready && !flush;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (hb_clk),
        .rst_n_i (rst_n),
        .push_i  (push),
        .wdata_i (s_data),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge hb_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            if (flush) begin
                terr_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= ISSUE;
                        wen_q   <= 1'b1;
                        wdata_q <= head;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_BUSY;
                    timer_q <= '0;
                end
                WAIT_BUSY: begin
                    if (!uart_tx_ready) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == TW'(BUSY_TIMEOUT)) begin
                        // UART never acknowledged the write: the byte is lost.
                        state_q <= IDLE;
                        if (!flush) begin
                            terr_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (uart_tx_ready) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_wen    = wen_q;
    assign uart_wdata  = wdata_q;
    assign byte_done   = done_q;
    assign timeout_err = terr_q;
    assign idle        = empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

    logic       hb_clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       flush;
    logic       tx_ready_w;
    logic       uart_wen;
    logic [7:0] uart_wdata;
    logic [3:0] level;
    logic       empty;
    logic       idle;
    logic       byte_done;
    logic       timeout_err;

    logic       stub_hold;
    logic       stub_stuck;
    int         busy_cnt;
    logic [7:0] strobes[$];
    int         dones;
    int         checks;
    int         errors;

    always #5 hb_clk = ~hb_clk;

    uart_tx_feeder #(.DEPTH(8), .BUSY_TIMEOUT(15)) dut (
        .hb_clk        (hb_clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .flush         (flush),
        .uart_tx_ready (tx_ready_w),
        .uart_wen      (uart_wen),
        .uart_wdata    (uart_wdata),
        .level         (level),
        .empty         (empty),
        .idle          (idle),
        .byte_done     (byte_done),
        .timeout_err   (timeout_err)
    );

    // UART stub: tx_ready drops the cycle after a strobe and stays low for 20 cycles.
    initial busy_cnt = 0;
    always @(posedge hb_clk) begin
        if (uart_wen && !stub_stuck) busy_cnt <= 20;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_ready_w = !stub_hold && (busy_cnt == 0);

    initial dones = 0;
    always @(negedge hb_clk) begin
        if (uart_wen) strobes.push_back(uart_wdata);
        if (byte_done) dones++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hb_clk);
        @(negedge hb_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && strobes.size() < n; i++) tick();
        check(tag, strobes.size(), n);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && !idle; i++) tick();
        check(tag, idle, 1);
    endtask

    initial begin
        int cnt;
        int d0;
        checks = 0; errors = 0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0;
        stub_hold = 1'b0; stub_stuck = 1'b0;
        @(negedge hb_clk); #1;
        tick(); tick();
        rst_n = 1'b1;

        // 1: reset state and single byte latency
        check("rst_wen", uart_wen, 0);
        check("rst_wdata", uart_wdata, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_idle", idle, 1);
        check("rst_done", byte_done, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_sready", s_ready, 1);
        push_byte(8'h55);
        check("t1_wen_c1", uart_wen, 0);
        check("t1_level", level, 1);
        tick();
        check("t1_wen_c2", uart_wen, 1);
        check("t1_wdata", uart_wdata, 8'h55);
        tick();
        check("t1_wen_pulse", uart_wen, 0);
        wait_idle(60, "t1_idle");
        check("t1_done", dones, 1);

        // 2+3: fill to 8, then a push while a pop fires
        strobes.delete(); dones = 0;
        stub_hold = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        check("t2_level8", level, 8);
        check("t2_sready0", s_ready, 0);
        stub_hold = 1'b0; s_valid = 1'b1; s_data = 8'h08;
        #1;
        check("t3_sready_full", s_ready, 0);
        tick();
        check("t3_level_pop", level, 7);
        tick();
        s_valid = 1'b0;
        check("t3_level_push", level, 8);
        wait_idle(400, "t2_idle");
        check("t2_nstrobe", strobes.size(), 9);
        for (int i = 0; i < 9 && i < strobes.size(); i++) check("t2_order", strobes[i], i);
        check("t2_ndone", dones, 9);

        // 4: tx_ready never drops after the strobe
        strobes.delete(); dones = 0;
        stub_stuck = 1'b1;
        push_byte(8'h3C);
        wait_strobes(1, 10, "t4_strobe");
        cnt = 0;
        while (!timeout_err && cnt < 40) begin tick(); cnt++; end
        check("t4_timeout_cycles", cnt, 17);
        check("t4_idle", idle, 1);
        check("t4_nodone", dones, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t4_flush_clr", timeout_err, 0);
        stub_stuck = 1'b0;

        // 5: flush during WAIT_DONE of the first of five bytes
        strobes.delete(); dones = 0;
        stub_hold = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        stub_hold = 1'b0;
        wait_strobes(1, 10, "t5_strobe");
        repeat (5) tick();
        check("t5_level_pre", level, 4);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t5_level_flush", level, 0);
        for (int i = 0; i < 40 && dones == 0; i++) tick();
        check("t5_done", dones, 1);
        repeat (60) tick();
        check("t5_nstrobe", strobes.size(), 1);
        check("t5_first", strobes[0], 8'h10);
        check("t5_idle", idle, 1);

        // 6: reset during WAIT_DONE with three bytes queued
        strobes.delete(); dones = 0;
        stub_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        stub_hold = 1'b0;
        wait_strobes(1, 10, "t6_strobe");
        repeat (5) tick();
        check("t6_level3", level, 3);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("t6_level", level, 0);
        check("t6_wen", uart_wen, 0);
        check("t6_wdata", uart_wdata, 0);
        check("t6_idle", idle, 1);
        check("t6_terr", timeout_err, 0);
        d0 = dones;
        repeat (40) tick();
        check("t6_nostrobe", strobes.size(), 1);
        check("t6_nodone", dones, d0);
        push_byte(8'hA5);
        wait_strobes(2, 10, "t6_new_strobe");
        check("t6_new_data", strobes[strobes.size()-1], 8'hA5);
        wait_idle(60, "t6_idle_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
